// File: rtl/lc3_mmio_bridge.sv
// lc3_mmio_bridge
//   Memory-mapped I/O bridge between the LC-3 core memory port and the
//   program/data RAM. It serves the device page registers locally:
//   KBSR, KBDR, DSR, DDR and MCR. All other accesses pass through to the RAM.
//   Device reads have the same one-cycle latency as RAM reads.
//
// Ports
//   clk, rst_n          : clock and synchronous active-low reset
//   mem_en, we          : core access request and write strobe
//   mem_addr, ram_data  : core address and write data
//   mem_data            : read data returned to the core, one cycle after the read
//   ram_en/we/addr/wdata: RAM request, combinational pass-through; masked on device hits
//   ram_rdata           : RAM read data, valid one cycle after ram_en
//   kb_valid/data/ready : keyboard byte stream into KBDR
//   dsp_valid/data/ready: display byte stream out of DDR
//   kb_irq, dsp_irq     : status-register interrupt decodes
//   halt                : high while MCR[15] is clear
module lc3_mmio_bridge #(
    parameter logic [15:0] KBSR_ADDR = 16'hFE00,
    parameter logic [15:0] KBDR_ADDR = 16'hFE02,
    parameter logic [15:0] DSR_ADDR  = 16'hFE04,
    parameter logic [15:0] DDR_ADDR  = 16'hFE06,
    parameter logic [15:0] MCR_ADDR  = 16'hFFFE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_en,
    input  logic        we,
    input  logic [15:0] mem_addr,
    input  logic [15:0] ram_data,
    output logic [15:0] mem_data,
    output logic        ram_en,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_ready,
    output logic        dsp_valid,
    output logic [7:0]  dsp_data,
    input  logic        dsp_ready,
    output logic        kb_irq,
    output logic        dsp_irq,
    output logic        halt
);

    logic        kb_full_q,  kb_full_d;
    logic        kb_ie_q,    kb_ie_d;
    logic [7:0]  kbdr_q,     kbdr_d;
    logic        dsp_pend_q, dsp_pend_d;
    logic        dsp_ie_q,   dsp_ie_d;
    logic [7:0]  ddr_q,      ddr_d;
    logic [15:0] mcr_q,      mcr_d;
    logic        sel_io_q,   sel_io_d;
    logic [15:0] io_rdata_q, io_rdata_d;

    logic hit_kbsr, hit_kbdr, hit_dsr, hit_ddr, hit_mcr, dev_hit;
    logic rd_cyc, wr_cyc;
    logic [15:0] io_mux;

    always_comb begin
        hit_kbsr = mem_en && (mem_addr == KBSR_ADDR);
        hit_kbdr = mem_en && (mem_addr == KBDR_ADDR);
        hit_dsr  = mem_en && (mem_addr == DSR_ADDR);
        hit_ddr  = mem_en && (mem_addr == DDR_ADDR);
        hit_mcr  = mem_en && (mem_addr == MCR_ADDR);
        dev_hit  = hit_kbsr | hit_kbdr | hit_dsr | hit_ddr | hit_mcr;
        rd_cyc   = mem_en & ~we;
        wr_cyc   = mem_en & we;

        io_mux = '0;
        if (hit_kbsr)     io_mux = {kb_full_q, kb_ie_q, 14'd0};
        else if (hit_kbdr) io_mux = {8'h00, kbdr_q};
        else if (hit_dsr)  io_mux = {~dsp_pend_q, dsp_ie_q, 14'd0};
        else if (hit_ddr)  io_mux = {8'h00, ddr_q};
        else if (hit_mcr)  io_mux = mcr_q;
    end

    assign ram_en    = mem_en & ~dev_hit;
    assign ram_we    = mem_en & we & ~dev_hit;
    assign ram_addr  = mem_addr;
    assign ram_wdata = ram_data;

    assign mem_data  = sel_io_q ? io_rdata_q : ram_rdata;
    assign kb_ready  = ~kb_full_q;
    assign dsp_valid = dsp_pend_q;
    assign dsp_data  = ddr_q;
    assign kb_irq    = kb_full_q & kb_ie_q;
    assign dsp_irq   = ~dsp_pend_q & dsp_ie_q;
    assign halt      = ~mcr_q[15];

    always_comb begin
        kb_full_d  = kb_full_q;
        kb_ie_d    = kb_ie_q;
        kbdr_d     = kbdr_q;
        dsp_pend_d = dsp_pend_q;
        dsp_ie_d   = dsp_ie_q;
        ddr_d      = ddr_q;
        mcr_d      = mcr_q;
        sel_io_d   = sel_io_q;
        io_rdata_d = io_rdata_q;

        // Intake is only possible while empty, so it never collides with a
        // KBDR read that still has a byte to clear.
        if (kb_valid && !kb_full_q) begin
            kb_full_d = 1'b1;
            kbdr_d    = kb_data;
        end else if (rd_cyc && hit_kbdr) begin
            kb_full_d = 1'b0;
        end

        if (wr_cyc && hit_kbsr) kb_ie_d  = ram_data[14];
        if (wr_cyc && hit_dsr)  dsp_ie_d = ram_data[14];
        if (wr_cyc && hit_mcr)  mcr_d    = ram_data;

        // DDR load and display handshake are mutually exclusive on the
        // pending flag; a write while pending is simply dropped.
        if (wr_cyc && hit_ddr && !dsp_pend_q) begin
            ddr_d      = ram_data[7:0];
            dsp_pend_d = 1'b1;
        end else if (dsp_pend_q && dsp_ready) begin
            dsp_pend_d = 1'b0;
        end

        if (rd_cyc) begin
            sel_io_d   = dev_hit;
            io_rdata_d = io_mux;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kb_full_q  <= 1'b0;
            kb_ie_q    <= 1'b0;
            kbdr_q     <= '0;
            dsp_pend_q <= 1'b0;
            dsp_ie_q   <= 1'b0;
            ddr_q      <= '0;
            mcr_q      <= 16'h8000;
            sel_io_q   <= 1'b0;
            io_rdata_q <= '0;
        end else begin
            kb_full_q  <= kb_full_d;
            kb_ie_q    <= kb_ie_d;
            kbdr_q     <= kbdr_d;
            dsp_pend_q <= dsp_pend_d;
            dsp_ie_q   <= dsp_ie_d;
            ddr_q      <= ddr_d;
            mcr_q      <= mcr_d;
            sel_io_q   <= sel_io_d;
            io_rdata_q <= io_rdata_d;
        end
    end

endmodule

// File: tb/tb_lc3_mmio_bridge.sv
// tb_lc3_mmio_bridge
//   Self-checking bench for lc3_mmio_bridge. Vectors drive one bus cycle each
//   and list the status outputs expected after that cycle's edge. Read data
//   expectations go through a FIFO scoreboard and are compared when the
//   one-cycle read latency has elapsed. A small RAM model answers pass-through
//   accesses.
module tb_lc3_mmio_bridge;

    localparam logic [15:0] KBSR = 16'hFE00;
    localparam logic [15:0] KBDR = 16'hFE02;
    localparam logic [15:0] DSR  = 16'hFE04;
    localparam logic [15:0] DDR  = 16'hFE06;
    localparam logic [15:0] MCR  = 16'hFFFE;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_en, we;
    logic [15:0] mem_addr, ram_data, mem_data;
    logic        ram_en, ram_we;
    logic [15:0] ram_addr, ram_wdata, ram_rdata;
    logic        kb_valid, kb_ready;
    logic [7:0]  kb_data;
    logic        dsp_valid, dsp_ready;
    logic [7:0]  dsp_data;
    logic        kb_irq, dsp_irq, halt;

    lc3_mmio_bridge #(
        .KBSR_ADDR(KBSR), .KBDR_ADDR(KBDR), .DSR_ADDR(DSR),
        .DDR_ADDR(DDR), .MCR_ADDR(MCR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mem_en(mem_en), .we(we),
        .mem_addr(mem_addr), .ram_data(ram_data), .mem_data(mem_data),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .kb_valid(kb_valid), .kb_data(kb_data), .kb_ready(kb_ready),
        .dsp_valid(dsp_valid), .dsp_data(dsp_data), .dsp_ready(dsp_ready),
        .kb_irq(kb_irq), .dsp_irq(dsp_irq), .halt(halt)
    );

    always #5 clk = ~clk;

    // RAM model: registered read, one cycle latency.
    logic [15:0] ram_model [0:65535];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_model[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram_model[ram_addr];
        end
    end

    typedef struct {
        logic        en;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wd;
        logic        kbv;
        logic [7:0]  kbd;
        logic        dr;
        logic [15:0] erd;
        logic        eram;
        logic        ekr;
        logic        edv;
        logic [7:0]  edd;
        logic        eh;
        logic        eki;
        logic        edi;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] rdq[$];
    int          total = 0;
    int          bad   = 0;
    int          stepno = 0;
    logic        rd_flag = 1'b0;

    function automatic void chk(string nm, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (step %0d): got %h expected %h", nm, stepno, act, exp);
        end
    endfunction

    // Read scoreboard: a read issued before an edge returns data after it.
    always @(posedge clk) rd_flag <= rst_n & mem_en & ~we;
    always @(negedge clk) begin
        if (rd_flag) begin
            if (rdq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rdata (step %0d): got %h expected none queued", stepno, mem_data);
            end else begin
                chk("rdata", mem_data, rdq.pop_front());
            end
        end
    end

    task automatic add(input logic en, input logic w, input logic [15:0] addr,
                       input logic [15:0] wd, input logic kbv, input logic [7:0] kbd,
                       input logic dr, input logic [15:0] erd, input logic eram,
                       input logic ekr, input logic edv, input logic [7:0] edd,
                       input logic eh, input logic eki, input logic edi);
        vec_t v;
        v.en = en; v.we = w; v.addr = addr; v.wd = wd; v.kbv = kbv; v.kbd = kbd;
        v.dr = dr; v.erd = erd; v.eram = eram; v.ekr = ekr; v.edv = edv;
        v.edd = edd; v.eh = eh; v.eki = eki; v.edi = edi;
        vecs.push_back(v);
    endtask

    // Called right after a falling edge: drive, check combinational RAM
    // controls, let one rising edge pass, check registered outputs.
    task automatic step(input vec_t v);
        stepno++;
        mem_en = v.en; we = v.we; mem_addr = v.addr; ram_data = v.wd;
        kb_valid = v.kbv; kb_data = v.kbd; dsp_ready = v.dr;
        if (v.en && !v.we && rst_n) rdq.push_back(v.erd);
        #1;
        chk("ram_en", {15'd0, ram_en}, {15'd0, v.eram});
        chk("ram_we", {15'd0, ram_we}, {15'd0, v.eram & v.we});
        if (v.eram) begin
            chk("ram_addr", ram_addr, v.addr);
            chk("ram_wdata", ram_wdata, v.wd);
        end
        @(posedge clk);
        @(negedge clk);
        chk("kb_ready",  {15'd0, kb_ready},  {15'd0, v.ekr});
        chk("dsp_valid", {15'd0, dsp_valid}, {15'd0, v.edv});
        chk("dsp_data",  {8'd0, dsp_data},   {8'd0, v.edd});
        chk("halt",      {15'd0, halt},      {15'd0, v.eh});
        chk("kb_irq",    {15'd0, kb_irq},    {15'd0, v.eki});
        chk("dsp_irq",   {15'd0, dsp_irq},   {15'd0, v.edi});
    endtask

    task automatic run_one(input logic en, input logic w, input logic [15:0] addr,
                           input logic [15:0] wd, input logic kbv, input logic [7:0] kbd,
                           input logic dr, input logic [15:0] erd, input logic eram,
                           input logic ekr, input logic edv, input logic [7:0] edd,
                           input logic eh, input logic eki, input logic edi);
        vecs.delete();
        add(en, w, addr, wd, kbv, kbd, dr, erd, eram, ekr, edv, edd, eh, eki, edi);
        step(vecs[0]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; mem_en = 1'b0; we = 1'b0; mem_addr = '0; ram_data = '0;
        kb_valid = 1'b0; kb_data = '0; dsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst kb_ready",  {15'd0, kb_ready},  16'd1);
        chk("rst dsp_valid", {15'd0, dsp_valid}, 16'd0);
        chk("rst dsp_data",  {8'd0, dsp_data},   16'd0);
        chk("rst halt",      {15'd0, halt},      16'd0);
        chk("rst irqs",      {14'd0, kb_irq, dsp_irq}, 16'd0);
        rst_n = 1'b1;

        //   en we addr   wd       kbv kbd   dr  erd      ram kr dv dd     h  ki di
        add(1, 0, MCR,    16'h0,   0, 8'h00, 0, 16'h8000, 0, 1, 0, 8'h00, 0, 0, 0);
        add(1, 0, DSR,    16'h0,   0, 8'h00, 0, 16'h8000, 0, 1, 0, 8'h00, 0, 0, 0);
        add(1, 0, KBSR,   16'h0,   0, 8'h00, 0, 16'h0000, 0, 1, 0, 8'h00, 0, 0, 0);
        add(0, 0, 16'h0,  16'h0,   1, 8'h41, 0, 16'h0000, 0, 0, 0, 8'h00, 0, 0, 0);
        add(1, 0, KBSR,   16'h0,   0, 8'h00, 0, 16'h8000, 0, 0, 0, 8'h00, 0, 0, 0);
        add(1, 0, KBDR,   16'h0,   0, 8'h00, 0, 16'h0041, 0, 1, 0, 8'h00, 0, 0, 0);
        add(1, 0, KBSR,   16'h0,   0, 8'h00, 0, 16'h0000, 0, 1, 0, 8'h00, 0, 0, 0);
        add(1, 1, DDR,    16'h0048,0, 8'h00, 0, 16'h0000, 0, 1, 1, 8'h48, 0, 0, 0);
        add(1, 0, DSR,    16'h0,   0, 8'h00, 0, 16'h0000, 0, 1, 1, 8'h48, 0, 0, 0);
        add(1, 1, DDR,    16'h0049,0, 8'h00, 0, 16'h0000, 0, 1, 1, 8'h48, 0, 0, 0);
        add(1, 0, DDR,    16'h0,   0, 8'h00, 0, 16'h0048, 0, 1, 1, 8'h48, 0, 0, 0);
        add(0, 0, 16'h0,  16'h0,   0, 8'h00, 1, 16'h0000, 0, 1, 0, 8'h48, 0, 0, 0);
        add(1, 0, DSR,    16'h0,   0, 8'h00, 0, 16'h8000, 0, 1, 0, 8'h48, 0, 0, 0);
        add(1, 1, KBSR,   16'hFFFF,0, 8'h00, 0, 16'h0000, 0, 1, 0, 8'h48, 0, 0, 0);
        add(1, 0, KBSR,   16'h0,   0, 8'h00, 0, 16'h4000, 0, 1, 0, 8'h48, 0, 0, 0);
        add(0, 0, 16'h0,  16'h0,   1, 8'h0A, 0, 16'h0000, 0, 0, 0, 8'h48, 0, 1, 0);
        add(1, 0, KBDR,   16'h0,   0, 8'h00, 0, 16'h000A, 0, 1, 0, 8'h48, 0, 0, 0);
        add(1, 1, 16'h3000,16'h1234,0,8'h00, 0, 16'h0000, 1, 1, 0, 8'h48, 0, 0, 0);
        add(1, 0, 16'h3000,16'h0,  0, 8'h00, 0, 16'h1234, 1, 1, 0, 8'h48, 0, 0, 0);
        add(1, 1, MCR,    16'h0000,0, 8'h00, 0, 16'h0000, 0, 1, 0, 8'h48, 1, 0, 0);
        add(1, 0, MCR,    16'h0,   0, 8'h00, 0, 16'h0000, 0, 1, 0, 8'h48, 1, 0, 0);
        add(1, 1, DSR,    16'hC000,0, 8'h00, 0, 16'h0000, 0, 1, 0, 8'h48, 1, 0, 1);
        add(1, 0, DSR,    16'h0,   0, 8'h00, 0, 16'hC000, 0, 1, 0, 8'h48, 1, 0, 1);
        add(1, 0, 16'h3000,16'h0,  0, 8'h00, 0, 16'h1234, 1, 1, 0, 8'h48, 1, 0, 1);
        add(1, 0, MCR,    16'h0,   0, 8'h00, 0, 16'h0000, 0, 1, 0, 8'h48, 1, 0, 1);
        add(1, 0, 16'h3000,16'h0,  0, 8'h00, 0, 16'h1234, 1, 1, 0, 8'h48, 1, 0, 1);
        add(1, 0, KBSR,   16'h0,   0, 8'h00, 0, 16'h4000, 0, 1, 0, 8'h48, 1, 0, 1);

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // KBDR read colliding with a new keyboard byte.
        run_one(0, 0, 16'h0, 16'h0, 1, 8'h55, 0, 16'h0000, 0, 0, 0, 8'h48, 1, 1, 1);
        run_one(1, 0, KBDR,  16'h0, 1, 8'h66, 0, 16'h0055, 0, 1, 0, 8'h48, 1, 0, 1);
        run_one(0, 0, 16'h0, 16'h0, 1, 8'h66, 0, 16'h0000, 0, 0, 0, 8'h48, 1, 1, 1);
        run_one(1, 0, KBDR,  16'h0, 0, 8'h00, 0, 16'h0066, 0, 1, 0, 8'h48, 1, 0, 1);

        // DDR write colliding with the display handshake.
        run_one(1, 1, DDR, 16'h0031, 0, 8'h00, 0, 16'h0000, 0, 1, 1, 8'h31, 1, 0, 0);
        run_one(1, 1, DDR, 16'h0032, 0, 8'h00, 1, 16'h0000, 0, 1, 0, 8'h31, 1, 0, 1);
        run_one(1, 1, DDR, 16'h0033, 0, 8'h00, 0, 16'h0000, 0, 1, 1, 8'h33, 1, 0, 0);

        // Reset with a display byte pending and a keyboard byte latched,
        // while other events try to fire in the same cycle.
        run_one(0, 0, 16'h0, 16'h0, 1, 8'h77, 0, 16'h0000, 0, 0, 1, 8'h33, 1, 1, 0);
        rst_n = 1'b0;
        run_one(1, 1, DDR, 16'h0099, 1, 8'h88, 1, 16'h0000, 0, 1, 0, 8'h00, 0, 0, 0);
        rst_n = 1'b1;
        run_one(1, 0, MCR,  16'h0, 0, 8'h00, 0, 16'h8000, 0, 1, 0, 8'h00, 0, 0, 0);
        run_one(1, 0, DSR,  16'h0, 0, 8'h00, 0, 16'h8000, 0, 1, 0, 8'h00, 0, 0, 0);
        run_one(1, 0, KBSR, 16'h0, 0, 8'h00, 0, 16'h0000, 0, 1, 0, 8'h00, 0, 0, 0);
        run_one(1, 0, KBDR, 16'h0, 0, 8'h00, 0, 16'h0000, 0, 1, 0, 8'h00, 0, 0, 0);
        run_one(1, 0, DDR,  16'h0, 0, 8'h00, 0, 16'h0000, 0, 1, 0, 8'h00, 0, 0, 0);
        run_one(0, 0, 16'h0, 16'h0, 0, 8'h00, 0, 16'h0000, 0, 1, 0, 8'h00, 0, 0, 0);

        total++;
        if (rdq.size() != 0) begin
            bad++;
            $display("FAIL rdq_drain: got %0d entries expected 0", rdq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lc3_mmio_bridge.md
# lc3_mmio_bridge

Memory-mapped I/O bridge between the LC3 core's memory port and the program/data RAM. It decodes the LC-3 device page: keyboard status/data, display status/data and the machine control register. Device accesses are served locally with the same one-cycle read latency as the RAM; all other accesses pass straight through. Keyboard input and display output leave the block as valid/ready byte streams.

## Interface
Parameters:
- `KBSR_ADDR`, 16'hFE00: keyboard status register.
- `KBDR_ADDR`, 16'hFE02: keyboard data register.
- `DSR_ADDR`, 16'hFE04: display status register.
- `DDR_ADDR`, 16'hFE06: display data register.
- `MCR_ADDR`, 16'hFFFE: machine control register.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `mem_en`, in, 1: core memory access request.
- `we`, in, 1: core write strobe, qualified by `mem_en`.
- `mem_addr`, in, 16: core address.
- `ram_data`, in, 16: core write data.
- `mem_data`, out, 16: read data returned to the core.
- `ram_en`, out, 1: RAM enable.
- `ram_we`, out, 1: RAM write enable.
- `ram_addr`, out, 16: RAM address.
- `ram_wdata`, out, 16: RAM write data.
- `ram_rdata`, in, 16: RAM read data; valid one cycle after the enable.
- `kb_valid`, in, 1: keyboard byte offered.
- `kb_data`, in, 8: keyboard byte.
- `kb_ready`, out, 1: bridge can accept a keyboard byte.
- `dsp_valid`, out, 1: display byte pending.
- `dsp_data`, out, 8: display byte.
- `dsp_ready`, in, 1: display sink accepts the byte.
- `kb_irq`, out, 1: KBSR[15] & KBSR[14].
- `dsp_irq`, out, 1: DSR[15] & DSR[14].
- `halt`, out, 1: asserted while MCR[15] = 0.

## Operation
- Device hit: `mem_en` is high and `mem_addr` equals one of the five register addresses. On a device hit, `ram_en` and `ram_we` are 0.
- Non-hit: `ram_en = mem_en`, `ram_we = mem_en & we`, `ram_addr = mem_addr`, `ram_wdata = ram_data`. All four are combinational.
- Read path:
  - Register `sel_io` and `io_rdata` on every `mem_en & ~we` cycle.
  - `mem_data = sel_io ? io_rdata : ram_rdata`.
- KBSR:
  - Bit 15: full flag. Bit 14: interrupt enable. Other bits read as 0.
  - A write updates only bit 14.
- KBDR:
  - Reads as {8'h00, byte}.
  - A read clears KBSR[15]. Writes are ignored.
- Keyboard intake:
  - `kb_ready = ~KBSR[15]`, driven from the registered flag with no bypass.
  - On `kb_valid & kb_ready`: latch `kb_data` into KBDR and set KBSR[15].
- DSR:
  - Bit 15: ready, which is the inverse of the pending flag. Bit 14: interrupt enable.
  - A write updates only bit 14.
- DDR:
  - A write while ready loads `ram_data[7:0]` into the output byte and sets pending.
  - A write while pending is dropped, with no state change.
  - Reads return {8'h00, last byte}.
- Display output:
  - `dsp_valid = pending`.
  - On `dsp_valid & dsp_ready`, pending clears at that edge.
- MCR:
  - Read/write 16-bit register. `halt = ~MCR[15]`.
  - The bridge keeps servicing the bus while halted; the core is responsible for stopping.

## Timing
- Reset values:
  - KBSR = 0, KBDR = 0, DSR = 16'h8000 (ready), DDR byte = 0, MCR = 16'h8000.
  - `sel_io` = 0, `io_rdata` = 0.
  - Outputs: `kb_ready` = 1, `dsp_valid` = 0, `dsp_data` = 0, `halt` = 0, both irqs = 0.
- Reset mid-operation: any pending display byte and any latched keyboard byte are discarded. Reset overrides all simultaneous events.
- Read latency is exactly 1 cycle for both RAM and device reads. Back-to-back reads alternating RAM and device return in order.
- Write effect: a device write takes effect at the sampling edge and is visible to a read issued on the next cycle.
- KBDR read and `kb_valid` in the same cycle: the read returns the old byte and clears the flag. The new byte is not accepted that cycle because `kb_ready` was 0; it is accepted on the next cycle.
- DDR write in the same cycle as a `dsp_ready` handshake: pending was 1 at that edge, so the write is dropped. A DDR write is accepted starting the cycle after the handshake.
- `halt` and both irqs are registered-state decodes with no combinational path from bus inputs.

## Test plan
- Reset, then read MCR, DSR and KBSR: returned one cycle after each access as 16'h8000, 16'h8000 and 16'h0000. `kb_ready` = 1, `dsp_valid` = 0, `halt` = 0.
- Drive `kb_valid` with 8'h41, then read KBSR and then KBDR:
  - `kb_ready` drops the next cycle.
  - KBSR reads 16'h8000 and KBDR reads 16'h0041.
  - A second KBSR read returns 16'h0000 and `kb_ready` returns to 1.
- Write 16'h0048 to DDR while `dsp_ready` = 0:
  - `dsp_valid` = 1, `dsp_data` = 8'h48, DSR reads 16'h0000.
  - A second DDR write of 16'h0049 is dropped.
  - Raise `dsp_ready` for one cycle: `dsp_valid` clears and DSR reads 16'h8000.
- Write KBSR = 16'hFFFF with no pending byte: KBSR reads 16'h4000 and `kb_irq` = 0. Inject 8'h0A: `kb_irq` = 1 until KBDR is read.
- Write 16'h1234 to address 16'h3000, then read it back: `ram_en`/`ram_we` pulse and `mem_data` = 16'h1234 one cycle after the read. Write MCR = 0: `halt` = 1 and `ram_en` stays 0 during the MCR access.
- Assert `rst_n` = 0 with a display byte pending and KBSR[15] set: after one clock edge all registers and outputs return to their reset values.
